// File: rtl/nibble_mem_seq_if.sv
// Request/response bus between a client and the nibble_mem random-access sequencer.
interface nibble_mem_seq_if #(
   parameter int unsigned AW = 6,
   parameter int unsigned DW = 4
);
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;

   // Client side: issues requests, receives completions
   modport master (
      output req_valid, req_write, req_addr, req_data,
      input  req_ready, rsp_valid, rsp_data
   );

   // Sequencer side
   modport slave (
      input  req_valid, req_write, req_addr, req_data,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/nibble_mem_seq.sv
// Random-access sequencer for nibble_mem: steers the relative cursor to an
// absolute address with next/prev pulses, then stores or samples dout.
// Optional macro NIBBLE_SEQ_SHORTEST_PATH_EN enables bidirectional
// shortest-path steering; without it the cursor only moves forward.
module nibble_mem_seq #(
   parameter int unsigned AW = 6,
   parameter int unsigned DW = 4
) (
   input  logic          clk,
   input  logic          rst,
   nibble_mem_seq_if.slave bus,
   output logic          mem_rst_n,
   output logic [DW-1:0] mem_din,
   output logic          mem_store,
   output logic          mem_next,
   output logic          mem_prev,
   input  logic [DW-1:0] mem_dout,
   input  logic [AW-1:0] mem_addr
);

   localparam int unsigned HALF = 2 ** (AW - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MOVE_PULSE,
      S_MOVE_GAP,
      S_SETTLE,
      S_STORE,
      S_STORE_GAP,
      S_RESP
   } state_t;

   state_t        r_state,     w_state;
   logic          r_write,     w_write;
   logic [DW-1:0] r_data,      w_data;
   logic [AW-1:0] r_cnt,       w_cnt;
   logic          r_req_ready, w_req_ready;
   logic          r_rsp_valid, w_rsp_valid;
   logic [DW-1:0] r_rsp_data,  w_rsp_data;
   logic          r_mem_store, w_mem_store;
   logic          r_mem_next,  w_mem_next;
   logic [AW-1:0] w_d;
`ifdef NIBBLE_SEQ_SHORTEST_PATH_EN
   logic          r_dir_prev,  w_dir_prev;
   logic          r_mem_prev,  w_mem_prev;
`endif

   assign mem_rst_n     = ~rst;
   assign mem_din       = r_data;
   assign mem_store     = r_mem_store;
   assign mem_next      = r_mem_next;
`ifdef NIBBLE_SEQ_SHORTEST_PATH_EN
   assign mem_prev      = r_mem_prev;
`else
   assign mem_prev      = 1'b0;
`endif
   assign bus.req_ready = r_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_write     <= 1'b0;
         r_data      <= '0;
         r_cnt       <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_mem_store <= 1'b0;
         r_mem_next  <= 1'b0;
`ifdef NIBBLE_SEQ_SHORTEST_PATH_EN
         r_dir_prev  <= 1'b0;
         r_mem_prev  <= 1'b0;
`endif
      end else begin
         r_state     <= w_state;
         r_write     <= w_write;
         r_data      <= w_data;
         r_cnt       <= w_cnt;
         r_req_ready <= w_req_ready;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_data  <= w_rsp_data;
         r_mem_store <= w_mem_store;
         r_mem_next  <= w_mem_next;
`ifdef NIBBLE_SEQ_SHORTEST_PATH_EN
         r_dir_prev  <= w_dir_prev;
         r_mem_prev  <= w_mem_prev;
`endif
      end
   end

   // Next state; outputs are decoded from the next state so they register cleanly
   always_comb begin
      w_state    = r_state;
      w_write    = r_write;
      w_data     = r_data;
      w_cnt      = r_cnt;
      w_rsp_data = r_rsp_data;
      w_d        = AW'(bus.req_addr - mem_addr);
`ifdef NIBBLE_SEQ_SHORTEST_PATH_EN
      w_dir_prev = r_dir_prev;
`endif

      case (r_state)
         S_IDLE: begin
            if (bus.req_valid && r_req_ready) begin
               w_write = bus.req_write;
               w_data  = bus.req_data;
`ifdef NIBBLE_SEQ_SHORTEST_PATH_EN
               // Tie at exactly half the ring resolves forward
               if (w_d > AW'(HALF)) begin
                  w_dir_prev = 1'b1;
                  w_cnt      = AW'(0) - w_d;
               end else begin
                  w_dir_prev = 1'b0;
                  w_cnt      = w_d;
               end
`else
               w_cnt = w_d;
`endif
               if (w_d != '0)          w_state = S_MOVE_PULSE;
               else if (bus.req_write) w_state = S_STORE;
               else                    w_state = S_SETTLE;
            end
         end
         S_MOVE_PULSE: begin
            w_cnt   = r_cnt - AW'(1);
            w_state = S_MOVE_GAP;
         end
         S_MOVE_GAP: begin
            if (r_cnt != '0)  w_state = S_MOVE_PULSE;
            else if (r_write) w_state = S_STORE;
            else              w_state = S_SETTLE;
         end
         S_SETTLE: begin
            w_rsp_data = mem_dout;
            w_state    = S_RESP;
         end
         S_STORE:     w_state = S_STORE_GAP;
         S_STORE_GAP: begin
            w_rsp_data = r_data;
            w_state    = S_RESP;
         end
         S_RESP:  w_state = S_IDLE;
         default: w_state = S_IDLE;
      endcase

      w_req_ready = (w_state == S_IDLE);
      w_rsp_valid = (w_state == S_RESP);
      w_mem_store = (w_state == S_STORE);
`ifdef NIBBLE_SEQ_SHORTEST_PATH_EN
      w_mem_next  = (w_state == S_MOVE_PULSE) && !w_dir_prev;
      w_mem_prev  = (w_state == S_MOVE_PULSE) &&  w_dir_prev;
`else
      w_mem_next  = (w_state == S_MOVE_PULSE);
`endif
   end

endmodule

// File: tb/tb_nibble_mem_seq.sv
// Bench for nibble_mem_seq: behavioural nibble_mem plus an abstract
// array/cursor reference model that predicts pulses, latency and data.
module tb_nibble_mem_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mem_rst_n;
   logic [3:0] mem_din;
   logic       mem_store, mem_next, mem_prev;
   logic [3:0] env_dout;
   logic [5:0] env_cur;
   logic [3:0] env_mem [64];

   int total = 0;
   int bad   = 0;

   bit [3:0] ref_mem [64];
   bit [5:0] ref_cur;

   nibble_mem_seq_if #(.AW(6), .DW(4)) bus ();

   nibble_mem_seq #(.AW(6), .DW(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mem_rst_n (mem_rst_n),
      .mem_din   (mem_din),
      .mem_store (mem_store),
      .mem_next  (mem_next),
      .mem_prev  (mem_prev),
      .mem_dout  (env_dout),
      .mem_addr  (env_cur)
   );

   always #5 clk = ~clk;

   // Behavioural nibble_mem: 64 x 4, cursor with auto-increment on store
   always @(posedge clk or negedge mem_rst_n) begin
      if (!mem_rst_n) begin
         env_cur <= '0;
         for (int i = 0; i < 64; i++) env_mem[i] <= '0;
      end else if (mem_store) begin
         env_mem[env_cur] <= mem_din;
         env_cur          <= env_cur + 6'd1;
      end else if (mem_next) begin
         env_cur <= env_cur + 6'd1;
      end else if (mem_prev) begin
         env_cur <= env_cur - 6'd1;
      end
   end
   assign env_dout = env_mem[env_cur];

   task automatic ref_clear();
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      ref_cur = '0;
   endtask

   // Issue one request and compare against the reference model; returns observations
   task automatic do_req(input bit wr, input bit [5:0] addr, input bit [3:0] data,
                         input bit hold, input string name,
                         output int o_next, output int o_prev, output bit [3:0] o_data);
      bit [5:0] d;
      int k, waitc, rsp_cyc, store_cyc, bad_pulse, ready_hi, np;
      bit dprev, prev_pulse;
      bit [3:0] exp_data;
      bit [5:0] exp_cur;
      d = addr - ref_cur;
      dprev = 1'b0;
`ifdef NIBBLE_SEQ_SHORTEST_PATH_EN
      if (d > 6'd32) begin
         dprev = 1'b1;
         k = 64 - int'(d);
      end else k = int'(d);
`else
      k = int'(d);
`endif
      exp_data = wr ? data : ref_mem[addr];
      exp_cur  = wr ? addr + 6'd1 : addr;

      waitc = 0;
      while (bus.req_ready !== 1'b1 && waitc < 200) begin
         @(negedge clk);
         waitc++;
      end
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s ready_wait: req_ready=%b required 1", name, bus.req_ready);
      end

      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_data  = data;
      o_next = 0; o_prev = 0; o_data = '0;
      rsp_cyc = -1; store_cyc = -1; bad_pulse = 0; ready_hi = 0; prev_pulse = 1'b0;
      for (int rel = 1; rel <= 140 && rsp_cyc < 0; rel++) begin
         @(negedge clk);
         if (hold) begin
            bus.req_write = 1'($urandom_range(0, 1));
            bus.req_addr  = 6'($urandom_range(0, 63));
            bus.req_data  = 4'($urandom_range(0, 15));
         end else bus.req_valid = 1'b0;
         np = int'(mem_next) + int'(mem_prev) + int'(mem_store);
         if (np > 1) bad_pulse++;
         if (np > 0 && prev_pulse) bad_pulse++;
         prev_pulse = (np > 0);
         if ((mem_next || mem_prev) && (rel % 2 == 0 || rel > 2 * k - 1)) bad_pulse++;
         if (mem_next) o_next++;
         if (mem_prev) o_prev++;
         if (mem_store) begin
            store_cyc = rel;
            if (mem_din !== data) bad_pulse++;
         end
         if (bus.req_ready) ready_hi++;
         if (bus.rsp_valid) begin
            rsp_cyc = rel;
            o_data  = bus.rsp_data;
            bus.req_valid = 1'b0;
         end
      end
      bus.req_valid = 1'b0;
      @(negedge clk);

      total++;
      if (o_next != (dprev ? 0 : k)) begin
         bad++;
         $display("FAIL %s next_count: got %0d required %0d", name, o_next, dprev ? 0 : k);
      end
      total++;
      if (o_prev != (dprev ? k : 0)) begin
         bad++;
         $display("FAIL %s prev_count: got %0d required %0d", name, o_prev, dprev ? k : 0);
      end
      total++;
      if (rsp_cyc != (wr ? 2 * k + 3 : 2 * k + 2)) begin
         bad++;
         $display("FAIL %s rsp_cycle: got T+%0d required T+%0d", name, rsp_cyc,
                  wr ? 2 * k + 3 : 2 * k + 2);
      end
      total++;
      if (store_cyc != (wr ? 2 * k + 1 : -1)) begin
         bad++;
         $display("FAIL %s store_cycle: got %0d required %0d", name, store_cyc,
                  wr ? 2 * k + 1 : -1);
      end
      total++;
      if (o_data !== exp_data) begin
         bad++;
         $display("FAIL %s rsp_data: got %h required %h", name, o_data, exp_data);
      end
      total++;
      if (bad_pulse != 0 || ready_hi != 0) begin
         bad++;
         $display("FAIL %s pulse_rules: violations=%0d ready_high_cycles=%0d required 0/0",
                  name, bad_pulse, ready_hi);
      end
      total++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || env_cur !== exp_cur) begin
         bad++;
         $display("FAIL %s after: rsp_valid=%b req_ready=%b cursor=%0d required 0/1/%0d",
                  name, bus.rsp_valid, bus.req_ready, env_cur, exp_cur);
      end

      if (wr) ref_mem[addr] = data;
      ref_cur = exp_cur;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (mem_rst_n !== 1'b0 || bus.req_ready !== 1'b1 || mem_next !== 1'b0 ||
          mem_prev !== 1'b0 || mem_store !== 1'b0 || bus.rsp_valid !== 1'b0 ||
          bus.rsp_data !== 4'h0 || mem_din !== 4'h0) begin
         bad++;
         $display("FAIL reset_state: rst_n=%b ready=%b n/p/s=%b%b%b rsp=%b data=%h din=%h required 0 1 000 0 0 0",
                  mem_rst_n, bus.req_ready, mem_next, mem_prev, mem_store,
                  bus.rsp_valid, bus.rsp_data, mem_din);
      end
      rst = 1'b0;
      ref_clear();
      @(negedge clk);
   endtask

   task automatic test_first_write();
      int n, p; bit [3:0] dd;
      do_req(1'b1, 6'd0, 4'hA, 1'b0, "wr0", n, p, dd);
      total++;
      if (n != 0 || p != 0 || env_cur !== 6'd1) begin
         bad++;
         $display("FAIL wr0_plan: next=%0d prev=%0d cursor=%0d required 0 0 1", n, p, env_cur);
      end
   endtask

   task automatic test_directed();
      int n, p; bit [3:0] dd;
      do_req(1'b1, 6'd5, 4'h3, 1'b0, "wr5", n, p, dd);
      total++;
      if (n != 4 || dd !== 4'h3 || env_cur !== 6'd6) begin
         bad++;
         $display("FAIL wr5_plan: next=%0d data=%h cursor=%0d required 4 3 6", n, dd, env_cur);
      end
      do_req(1'b0, 6'd5, 4'h0, 1'b0, "rd5", n, p, dd);
`ifdef NIBBLE_SEQ_SHORTEST_PATH_EN
      total++;
      if (p != 1 || n != 0 || dd !== 4'h3) begin
         bad++;
         $display("FAIL rd5_plan: prev=%0d next=%0d data=%h required 1 0 3", p, n, dd);
      end
`else
      total++;
      if (n != 63 || p != 0 || dd !== 4'h3) begin
         bad++;
         $display("FAIL rd5_plan: next=%0d prev=%0d data=%h required 63 0 3", n, p, dd);
      end
`endif
      do_req(1'b0, 6'd0, 4'h0, 1'b0, "rd0", n, p, dd);
      total++;
      if (dd !== 4'hA) begin
         bad++;
         $display("FAIL rd0_plan: data=%h required a", dd);
      end
      do_req(1'b0, 6'd63, 4'h0, 1'b0, "rd63", n, p, dd);
      total++;
      if (env_cur !== 6'd63) begin
         bad++;
         $display("FAIL rd63_plan: cursor=%0d required 63", env_cur);
      end
   endtask

   task automatic test_tie_hold();
      int n, p; bit [3:0] dd;
      do_req(1'b0, 6'd0, 4'h0, 1'b0, "rd0_wrap", n, p, dd);
      do_req(1'b0, 6'd32, 4'h0, 1'b1, "rd32_tie", n, p, dd);
      total++;
      if (n != 32 || p != 0) begin
         bad++;
         $display("FAIL tie_plan: next=%0d prev=%0d required 32 0", n, p);
      end
   endtask

   task automatic test_reset_mid();
      int n, p, rsp_seen; bit [3:0] dd;
      do_req(1'b0, 6'd0, 4'h0, 1'b0, "rd0_pre", n, p, dd);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 6'd10;
      bus.req_data  = 4'h0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (mem_next !== 1'b0 || mem_prev !== 1'b0 || mem_store !== 1'b0 ||
          bus.rsp_valid !== 1'b0 || env_cur !== 6'd0 || bus.req_ready !== 1'b1) begin
         bad++;
         $display("FAIL abort: n/p/s=%b%b%b rsp=%b cursor=%0d ready=%b required 000 0 0 1",
                  mem_next, mem_prev, mem_store, bus.rsp_valid, env_cur, bus.req_ready);
      end
      rst = 1'b0;
      ref_clear();
      rsp_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.rsp_valid) rsp_seen++;
      end
      total++;
      if (rsp_seen != 0) begin
         bad++;
         $display("FAIL abort_no_rsp: rsp_valid cycles=%0d required 0", rsp_seen);
      end
      do_req(1'b0, 6'd0, 4'h0, 1'b0, "rd0_post", n, p, dd);
      total++;
      if (dd !== 4'h0) begin
         bad++;
         $display("FAIL post_reset_data: data=%h required 0", dd);
      end
   endtask

   task automatic test_random_back_to_back();
      int n, p; bit [3:0] dd;
      for (int i = 0; i < 30; i++) begin
         do_req(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "random", n, p, dd);
      end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      ref_clear();
      test_reset();
      test_first_write();
      test_directed();
      test_tie_hold();
      test_reset_mid();
      test_random_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nibble_mem_seq.md
Name: nibble_mem_seq

Overview:
- Random-access sequencer in front of nibble_mem (64 x 4-bit, relative cursor: store / next / prev pulses, addr / dout readback).
- Accepts absolute read/write requests over a valid/ready port.
- Steers the nibble_mem cursor to the target word with single-cycle next/prev pulses, then performs a store or samples dout.
- Returns one response per request; owns nibble_mem reset.

Parameters:
- AW, 6, address width; depth = 2^AW; must match nibble_mem.
- DW, 4, data width; must match nibble_mem.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer when req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  AW  target word
- req_data  in  DW  write data (ignored for reads)
- rsp_valid  out  1  one-cycle completion strobe
- rsp_data  out  DW  read data, or echoed write data
- mem_rst_n  out  1  to nibble_mem rst_n; equals ~rst, combinational
- mem_din  out  DW  to nibble_mem din
- mem_store  out  1  to nibble_mem store, registered
- mem_next  out  1  to nibble_mem next, registered
- mem_prev  out  1  to nibble_mem prev, registered
- mem_dout  in  DW  from nibble_mem dout
- mem_addr  in  AW  from nibble_mem addr (current cursor)

Behaviour:
- Reset values:
  - state = IDLE; req_ready = 1.
  - rsp_valid, mem_store, mem_next, mem_prev = 0.
  - rsp_data, mem_din, latched request = 0.
  - Reset mid-operation aborts the operation: no response, pulses drop at the next edge, cursor returns to 0 through mem_rst_n.
- Acceptance:
  - Request accepted in cycle T latches write, addr and data.
  - Inputs are ignored whenever req_ready = 0; no queueing.
- Distance: d = (req_addr - mem_addr) mod 2^AW, sampled at acceptance; AW-bit unsigned subtraction.
  - d = 0: no move.
  - d <= 2^(AW-1): direction NEXT, k = d steps.
  - Otherwise: direction PREV, k = 2^AW - d steps.
  - d = 32 resolves to NEXT.
  - Step counter holds AW bits.
- States:
  - IDLE -> MOVE when k > 0.
  - IDLE -> SETTLE for a read with k = 0.
  - IDLE -> STORE for a write with k = 0.
  - MOVE: pulse cycle (next or prev = 1), then gap cycle (all pulses 0), repeated k times.
  - After the last gap: read -> SETTLE, write -> STORE.
  - SETTLE: one cycle, no pulses; mem_dout captured into rsp_data at the end of this cycle -> RESP.
  - STORE: mem_din = latched data; mem_store = 1 for one cycle; then one gap cycle -> RESP.
  - RESP: rsp_valid = 1 for one cycle; req_ready = 0; -> IDLE.
- Timing for a request accepted in T with k steps:
  - Move pulses in cycles T+1, T+3, ..., T+2k-1.
  - Read: rsp_valid in T+2k+2.
  - Write: mem_store in T+2k+1, rsp_valid in T+2k+3.
  - Next acceptance no earlier than the cycle after rsp_valid.
- Pulse rules:
  - At most one of store/next/prev is high in any cycle.
  - Every pulse is exactly one cycle and is followed by at least one all-zero cycle.
- Cursor after completion: read leaves cursor = req_addr; write leaves cursor = req_addr + 1 mod 2^AW (nibble_mem auto-increment).
- Wrap-around: cursor 63 + next -> 0 and cursor 0 + prev -> 63 are handled by nibble_mem; the sequencer relies on mem_addr, not a shadow copy.

Optional Feature:
- Macro NIBBLE_SEQ_SHORTEST_PATH_EN.
  - Defined: bidirectional shortest-path steering as above.
  - Undefined: direction is always NEXT with k = d (0..63); mem_prev is tied to 0. All other timing is unchanged.

Test Plan:
1. Reset 3 cycles; check initial state and a write.
   - During reset: mem_rst_n = 0, req_ready = 1, all pulses 0.
   - Then write addr 0 data 0xA -> no move pulses, mem_store in T+1, rsp_valid in T+3, mem_addr = 1.
2. Cursor 1, write addr 5 data 0x3 -> 4 mem_next pulses, store, rsp_valid in T+11, rsp_data = 0x3, mem_addr = 6.
3. Cursor 6, read addr 5 -> 1 mem_prev pulse, rsp_valid in T+4, rsp_data = 0x3.
   - Without the macro: 63 mem_next pulses, rsp_valid in T+128, same data.
4. Cursor 5, read addr 0 -> 5 prev pulses, rsp_data = 0xA.
   - Then read addr 63 from cursor 0 -> 1 prev pulse (wrap), cursor 63.
5. Cursor 0, read addr 32 -> tie case: 32 next pulses, never prev.
   - Hold req_valid with new values throughout -> ignored until req_ready = 1.
6. Assert rst during the MOVE of a 10-step request -> next cycle all pulses 0, no rsp_valid, mem_addr = 0.
   - A fresh read addr 0 afterwards completes normally with rsp_data = 0.
